// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter: shares one bus between the instruction-fetch
// port and the load/store port with round-robin tie-breaking, one command in
// flight, response routed back to the owner, and a timeout abort for hung slaves.
module mem_bus_arbiter #(
  parameter logic [1:0]  FETCH_HB = 2'b10,
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // Fetch master
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  // Load/store master
  input  logic        ls_req_i,
  input  logic [31:0] ls_addr_i,
  input  logic        ls_we_i,
  input  logic [1:0]  ls_hb_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        ls_err_o,
  // Shared bus
  output logic        m_req_o,
  output logic [31:0] m_addr_o,
  output logic        m_we_o,
  output logic [1:0]  m_hb_o,
  output logic [31:0] m_wdata_o,
  input  logic        m_ready_i,
  input  logic [31:0] m_rdata_i
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      r_state;
  logic        r_last_ls;   // last grant went to load/store (reset: fetch)
  logic        r_owner_ls;  // owner of the outstanding command
  logic [7:0]  r_tmo_cnt;

  logic        r_m_req;
  logic [31:0] r_m_addr;
  logic        r_m_we;
  logic [1:0]  r_m_hb;
  logic [31:0] r_m_wdata;

  logic        r_if_rvalid;
  logic        r_ls_rvalid;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_can_grant;
  logic        w_if_gnt;
  logic        w_ls_gnt;
  logic        w_timeout;

  // Combinational grant: RESP arbitrates like IDLE; ties go to the master not granted last.
  always_comb begin
    w_can_grant = rst_ni && (r_state != StBusy);
    w_if_gnt    = w_can_grant && if_req_i && (!ls_req_i || r_last_ls);
    w_ls_gnt    = w_can_grant && ls_req_i && (!if_req_i || !r_last_ls);
    w_timeout   = (r_tmo_cnt == TMO_LAST);
  end

  // Arbiter FSM with registered bus command and response outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_last_ls   <= 1'b0;
      r_owner_ls  <= 1'b0;
      r_tmo_cnt   <= 8'd0;
      r_m_req     <= 1'b0;
      r_m_addr    <= 32'd0;
      r_m_we      <= 1'b0;
      r_m_hb      <= 2'b00;
      r_m_wdata   <= 32'd0;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      unique case (r_state)
        StIdle, StResp: begin
          if (w_if_gnt || w_ls_gnt) begin
            r_state    <= StBusy;
            r_m_req    <= 1'b1;
            r_tmo_cnt  <= 8'd0;
            r_owner_ls <= w_ls_gnt;
            r_last_ls  <= w_ls_gnt;
            if (w_ls_gnt) begin
              r_m_addr  <= ls_addr_i;
              r_m_we    <= ls_we_i;
              r_m_hb    <= ls_hb_i;
              r_m_wdata <= ls_wdata_i;
            end else begin
              r_m_addr  <= if_addr_i;
              r_m_we    <= 1'b0;
              r_m_hb    <= FETCH_HB;
              r_m_wdata <= 32'd0;
            end
          end else begin
            r_state <= StIdle;
          end
        end
        StBusy: begin
          // Slave completion takes priority over a timeout in the same cycle.
          if (m_ready_i || w_timeout) begin
            r_state     <= StResp;
            r_m_req     <= 1'b0;
            r_rdata     <= m_ready_i ? m_rdata_i : ERR_DATA;
            r_err       <= !m_ready_i;
            r_if_rvalid <= !r_owner_ls;
            r_ls_rvalid <= r_owner_ls;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Output wiring from the command and capture registers.
  always_comb begin
    if_gnt_o    = w_if_gnt;
    ls_gnt_o    = w_ls_gnt;
    if_rvalid_o = r_if_rvalid;
    ls_rvalid_o = r_ls_rvalid;
    if_rdata_o  = r_rdata;
    ls_rdata_o  = r_rdata;
    if_err_o    = r_if_rvalid && r_err;
    ls_err_o    = r_ls_rvalid && r_err;
    m_req_o     = r_m_req;
    m_addr_o    = r_m_addr;
    m_we_o      = r_m_we;
    m_hb_o      = r_m_hb;
    m_wdata_o   = r_m_wdata;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter that shares the single memory bus (ROM/RAM/UART decode stage) between the instruction-fetch port and the load/store data port. It accepts one request at a time with round-robin fairness, holds the granted command on the bus until the slave completes it, routes the response back to the owning master, and aborts hung accesses after a timeout. It sits between the core's two master ports and the address-decode/load-store stage.

## Interface
- FETCH_HB, 2'b10: size code driven on m_hb_o for fetches; 2'b10 is the word encoding.
- TIMEOUT, 16: cycles m_req_o may stay high without m_ready_i before abort; legal range 2..255.
- ERR_DATA, 32'hDEADBEEF: rdata returned on an aborted access.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- if_req_i / if_addr_i  in  1 / 32  fetch request; address.
- if_gnt_o  out  1  fetch request accepted this cycle.
- if_rvalid_o / if_rdata_o / if_err_o  out  1 / 32 / 1  fetch response.
- ls_req_i / ls_addr_i / ls_we_i / ls_hb_i / ls_wdata_i  in  1 / 32 / 1 / 2 / 32  data request.
- ls_gnt_o  out  1  data request accepted this cycle.
- ls_rvalid_o / ls_rdata_o / ls_err_o  out  1 / 32 / 1  data response.
- m_req_o / m_addr_o / m_we_o / m_hb_o / m_wdata_o  out  1 / 32 / 1 / 2 / 32  bus command.
- m_ready_i  in  1  slave completes the current command this cycle.
- m_rdata_i  in  32  slave read data, valid when m_ready_i=1.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if any req_i is high, grant one: gnt_o is combinational, high in the same cycle. Latch addr/we/hb/wdata, and the owner, into command registers, then go to BUSY.
  - A fetch latches we=0, hb=FETCH_HB, wdata=0.
- Arbitration:
  - Only one request: that master wins.
  - Both requesting: the master not granted last wins.
  - The last-granted pointer updates on every grant and resets to "fetch", so the data port wins the first tie after reset.
- BUSY:
  - m_req_o=1 and the m_* outputs are driven from the command registers and held stable.
  - Timeout counter increments each BUSY cycle.
  - m_ready_i=1: capture m_rdata_i, clear err, go to RESP.
  - Otherwise, counter reaches TIMEOUT-1: capture ERR_DATA, set err, go to RESP.
  - If both happen in the same cycle, m_ready_i wins.
- RESP:
  - The owner's rvalid_o=1 for exactly one cycle, with rdata_o and err_o from the capture registers. The non-owner's rvalid_o=0.
  - Writes also produce a response pulse (write acknowledge); its rdata_o is the captured m_rdata_i.
  - The RESP cycle behaves as IDLE for arbitration: a pending request is granted in the same cycle and goes to BUSY, otherwise go to IDLE.
- Masters hold req/addr/data stable until gnt. Dropping req before gnt withdraws the request without side effects.
- The arbiter never issues gnt to both masters in one cycle. At most one command is outstanding.

## Timing
- Reset values of all outputs: gnt, rvalid, err, m_req_o, m_we_o = 0; rdata, m_addr_o, m_wdata_o = 0; m_hb_o = 2'b00.
- Internal reset state: state=IDLE, timeout counter=0, last-granted pointer="fetch".
- Asserting rst_ni low mid-access drops m_req_o asynchronously. No response is ever delivered for the aborted command.
- Timing with slave ready immediately:
  - gnt in cycle N.
  - m_req_o in N+1 with m_ready_i=1.
  - rvalid in N+2 (response latency 2 cycles from gnt).
  - Next gnt possible in N+2, giving one access per 2 cycles.
- Slave with k wait cycles: rvalid arrives at N+2+k.
- Timeout: rvalid with err=1 in cycle N+1+TIMEOUT.
- m_* outputs change only on BUSY entry. Outside BUSY, m_req_o=0 and the other m_* outputs hold their last values.

## Test plan
- Fetch only: if_req_i=1, if_addr_i=0x10, m_ready_i=1, m_rdata_i=0x00000013 -> if_gnt_o in cycle 0; m_addr_o=0x10, m_hb_o=2'b10, m_we_o=0 in cycle 1; if_rvalid_o=1, if_rdata_o=0x13, if_err_o=0 in cycle 2.
- Simultaneous requests right after reset, held high -> grants alternate: ls, if, ls, if (ls_gnt_o in cycles 0 and 4, if_gnt_o in cycles 2 and 6), never both in one cycle.
- Data write: ls_we_i=1, addr=0x104, wdata=0xA5A5A5A5, hb=2'b00, m_ready_i low for 3 cycles -> m_* held stable for 4 cycles; ls_rvalid_o exactly 1 cycle in cycle 5; if_rvalid_o stays 0.
- Timeout: m_ready_i=0 forever, TIMEOUT=16 -> ls_rvalid_o=1, ls_err_o=1, ls_rdata_o=0xDEADBEEF in cycle 17; the next request is granted normally.
- Reset mid-BUSY: rst_ni low in cycle 1 of an access -> m_req_o=0 immediately; no rvalid after release; first tie after release goes to ls.
- m_ready_i asserted in the same cycle the timeout expires -> err=0 and rdata equals m_rdata_i.
